// File: rtl/ej32_pkg.sv
// Shared types for the ej32 core: fetch FSM states, opcodes, stack operations.
package ej32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef enum logic [7:0] {
        OP_NOP    = 8'h00,
        OP_ICONST = 8'h03,
        OP_IADD   = 8'h60,
        OP_ISUB   = 8'h64,
        OP_GOTO   = 8'ha7,
        OP_IRET   = 8'hac
    } opcode_t;

    typedef enum logic [1:0] {
        SOP_NONE = 2'd0,
        SOP_PUSH = 2'd1,
        SOP_POP  = 2'd2,
        SOP_SWAP = 2'd3
    } stack_op;

endpackage

// File: rtl/ej32_fetch_if.sv
// Fetch unit bus: redirect input, byte memory port and decoder byte stream.
interface ej32_fetch_if #(
    parameter int unsigned ASZ = 17
);
    logic           br_psel;
    logic [ASZ-1:0] br_p;
    logic           mem_req;
    logic [ASZ-1:0] mem_addr;
    logic           mem_ack;
    logic [7:0]     mem_data;
    logic           dec_rdy;
    logic           byte_vld;
    logic [7:0]     byte_o;
    logic [ASZ-1:0] p_o;

    modport master (
        input  br_psel, br_p, mem_ack, mem_data, dec_rdy,
        output mem_req, mem_addr, byte_vld, byte_o, p_o
    );

    modport slave (
        output br_psel, br_p, mem_ack, mem_data, dec_rdy,
        input  mem_req, mem_addr, byte_vld, byte_o, p_o
    );
endinterface

// File: rtl/ej32_fq.sv
// Prefetch byte queue: QD entries, each a byte plus the address it was fetched from.
module ej32_fq #(
    parameter int unsigned QD  = 4,
    parameter int unsigned ASZ = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [7:0]                 wdata,
    input  logic [ASZ-1:0]             waddr,
    output logic [$clog2(QD+1)-1:0]    count,
    output logic [7:0]                 rdata,
    output logic [ASZ-1:0]             raddr
);
    localparam int unsigned PW = $clog2(QD);
    localparam int unsigned CW = $clog2(QD + 1);

    logic [7:0]     data_q [QD];
    logic [ASZ-1:0] tag_q  [QD];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;

    // Pointer and occupancy update; flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage needs no reset: only entries below count are ever read as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail] <= wdata;
            tag_q[tail]  <= waddr;
        end
    end

    assign rdata = data_q[head];
    assign raddr = tag_q[head];
endmodule

// File: rtl/ej32_fetch.sv
// Instruction byte fetch: single-outstanding byte reads into a prefetch queue, with redirect.
module ej32_fetch
    import ej32_pkg::*;
#(
    parameter int unsigned ASZ = 17,
    parameter int unsigned QD  = 4
) (
    input  logic         clk,
    input  logic         rst,
    ej32_fetch_if.master bus
);
    localparam int unsigned CW  = $clog2(QD + 1);
    localparam int unsigned CW1 = CW + 1;

    fetch_state_t   state;
    fetch_state_t   state_nxt;
    logic [ASZ-1:0] fp;
    logic [ASZ-1:0] fp_nxt;
    logic [CW-1:0]  count;
    logic [CW:0]    count_after;
    logic           push;
    logic           pop;
    logic           flush;
    logic [7:0]     head_data;
    logic [ASZ-1:0] head_addr;

    ej32_fq #(.QD(QD), .ASZ(ASZ)) u_fq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (bus.mem_data),
        .waddr (fp),
        .count (count),
        .rdata (head_data),
        .raddr (head_addr)
    );

    // State and fetch pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            fp    <= '0;
        end else begin
            state <= state_nxt;
            fp    <= fp_nxt;
        end
    end

    // Next state, fetch pointer and queue controls; a redirect cancels any push or pop.
    always_comb begin
        state_nxt   = state;
        fp_nxt      = fp;
        flush       = bus.br_psel;
        pop         = (count != '0) && bus.dec_rdy && !bus.br_psel;
        push        = (state == REQ) && bus.mem_ack && !bus.br_psel;
        count_after = CW1'(count) + CW1'(push) - CW1'(pop);
        case (state)
            IDLE: begin
                if (bus.br_psel) begin
                    fp_nxt    = bus.br_p;
                    state_nxt = REQ;
                end else if (count < CW'(QD)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.br_psel) begin
                    fp_nxt    = bus.br_p;
                    state_nxt = bus.mem_ack ? REQ : DRAIN;
                end else if (bus.mem_ack) begin
                    fp_nxt    = fp + ASZ'(1);
                    state_nxt = (count_after < CW1'(QD)) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                // The ack that ends the drain also ends it under a fresh redirect,
                // otherwise the FSM would wait for an ack that never comes.
                if (bus.br_psel) fp_nxt = bus.br_p;
                if (bus.mem_ack) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_req  = (state == REQ);
    assign bus.mem_addr = fp;
    assign bus.byte_vld = (count != '0);
    assign bus.byte_o   = head_data;
    assign bus.p_o      = head_addr;
endmodule

// File: tb/tb_ej32_fetch.sv
// Directed bench for ej32_fetch: per-cycle vector table plus redirect/wrap/reset sequences.
module tb_ej32_fetch;
    import ej32_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Memory model controls
    logic        mem_en = 1'b1;
    int          mem_delay = 0;
    logic        ack_force = 1'b0;
    logic [7:0]  force_data = 8'h00;
    logic        mbusy = 1'b0;
    int          mcnt = 0;
    logic [16:0] maddr = '0;

    ej32_fetch_if #(.ASZ(17)) bus ();

    ej32_fetch #(.ASZ(17), .QD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // Byte memory returning data = addr[7:0]; zero delay acks in the request cycle.
    always_comb begin
        if (mbusy) begin
            bus.mem_ack  = (mcnt >= mem_delay);
            bus.mem_data = maddr[7:0];
        end else begin
            bus.mem_ack  = mem_en && bus.mem_req && (mem_delay == 0);
            bus.mem_data = bus.mem_addr[7:0];
        end
        if (ack_force) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = force_data;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
        end else if (!mbusy && mem_en && bus.mem_req && !bus.mem_ack) begin
            mbusy <= 1'b1;
            mcnt  <= 1;
            maddr <= bus.mem_addr;
        end else if (mbusy && bus.mem_ack) begin
            mbusy <= 1'b0;
        end else if (mbusy) begin
            mcnt <= mcnt + 1;
        end
    end

    typedef struct {
        logic        dec_rdy;
        logic        exp_req;
        logic [16:0] exp_addr;
        logic        exp_vld;
        logic [7:0]  exp_byte;
        logic [16:0] exp_p;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(logic d, logic r, logic [16:0] a, logic v,
                                logic [7:0] b, logic [16:0] p);
        vec_t t;
        t.dec_rdy = d; t.exp_req = r; t.exp_addr = a;
        t.exp_vld = v; t.exp_byte = b; t.exp_p = p;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.br_psel = 1'b0;
        bus.br_p = '0;
        bus.dec_rdy = 1'b0;
        ack_force = 1'b0;
        repeat (2) step();
    endtask

    // Leaves a request to 0x0005 outstanding at a 3-cycle memory, queue drained by the decoder.
    task automatic go_outstanding();
        logic found;
        found = 1'b0;
        do_reset();
        rst = 1'b1;
        mem_en = 1'b1;
        mem_delay = 0;
        bus.dec_rdy = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.mem_addr == 17'h5) found = 1'b1;
        end
        chk("find_addr5", 32'(found), 32'd1);
        mem_delay = 3;
        step();
        chk("pend_req", 32'(bus.mem_req), 32'd1);
        chk("pend_ack", 32'(bus.mem_ack), 32'd0);
    endtask

    initial begin
        int nreq;
        vecs[0]  = mk(1'b1, 1'b1, 17'h00, 1'b0, 8'h00, 17'h00);
        vecs[1]  = mk(1'b1, 1'b1, 17'h01, 1'b1, 8'h00, 17'h00);
        vecs[2]  = mk(1'b1, 1'b1, 17'h02, 1'b1, 8'h01, 17'h01);
        vecs[3]  = mk(1'b1, 1'b1, 17'h03, 1'b1, 8'h02, 17'h02);
        vecs[4]  = mk(1'b1, 1'b1, 17'h04, 1'b1, 8'h03, 17'h03);
        vecs[5]  = mk(1'b1, 1'b1, 17'h05, 1'b1, 8'h04, 17'h04);
        vecs[6]  = mk(1'b1, 1'b1, 17'h06, 1'b1, 8'h05, 17'h05);
        vecs[7]  = mk(1'b1, 1'b1, 17'h07, 1'b1, 8'h06, 17'h06);
        vecs[8]  = mk(1'b1, 1'b1, 17'h08, 1'b1, 8'h07, 17'h07);
        vecs[9]  = mk(1'b1, 1'b1, 17'h09, 1'b1, 8'h08, 17'h08);
        vecs[10] = mk(1'b1, 1'b1, 17'h0a, 1'b1, 8'h09, 17'h09);
        vecs[11] = mk(1'b1, 1'b1, 17'h0b, 1'b1, 8'h0a, 17'h0a);
        vecs[12] = mk(1'b0, 1'b1, 17'h0c, 1'b1, 8'h0a, 17'h0a);
        vecs[13] = mk(1'b0, 1'b1, 17'h0d, 1'b1, 8'h0a, 17'h0a);
        vecs[14] = mk(1'b0, 1'b0, 17'h0e, 1'b1, 8'h0a, 17'h0a);
        vecs[15] = mk(1'b0, 1'b0, 17'h0e, 1'b1, 8'h0a, 17'h0a);
        vecs[16] = mk(1'b1, 1'b0, 17'h0e, 1'b1, 8'h0b, 17'h0b);
        vecs[17] = mk(1'b1, 1'b1, 17'h0e, 1'b1, 8'h0c, 17'h0c);
        vecs[18] = mk(1'b1, 1'b1, 17'h0f, 1'b1, 8'h0d, 17'h0d);
        vecs[19] = mk(1'b1, 1'b1, 17'h10, 1'b1, 8'h0e, 17'h0e);

        // Reset state
        do_reset();
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_vld", 32'(bus.byte_vld), 32'd0);
        chk("rst_count", 32'(dut.u_fq.count), 32'd0);
        rst = 1'b1;

        // Streaming, back-pressure fill to QD, and restart
        for (int i = 0; i < 20; i++) begin
            bus.dec_rdy = vecs[i].dec_rdy;
            step();
            chk($sformatf("v%0d_req", i), 32'(bus.mem_req), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d_vld", i), 32'(bus.byte_vld), 32'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) begin
                chk($sformatf("v%0d_byte", i), 32'(bus.byte_o), 32'(vecs[i].exp_byte));
                chk($sformatf("v%0d_p", i), 32'(bus.p_o), 32'(vecs[i].exp_p));
            end
        end

        // Stalled decoder from reset: exactly QD requests
        do_reset();
        rst = 1'b1;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mem_req && bus.mem_ack) nreq++;
        end
        chk("fill_nreq", 32'(nreq), 32'd4);
        chk("fill_count", 32'(dut.u_fq.count), 32'd4);
        chk("fill_req", 32'(bus.mem_req), 32'd0);
        chk("fill_byte", 32'(bus.byte_o), 32'h00);
        chk("fill_p", 32'(bus.p_o), 32'h0);

        // Redirect with a request in flight: drain and drop byte 0x05
        go_outstanding();
        bus.br_psel = 1'b1;
        bus.br_p = 17'h10000;
        step();
        bus.br_psel = 1'b0;
        chk("drain_state", 32'(dut.state), 32'(DRAIN));
        chk("drain_req", 32'(bus.mem_req), 32'd0);
        chk("drain_vld", 32'(bus.byte_vld), 32'd0);
        step();
        chk("drain_ack_now", 32'(bus.mem_ack), 32'd1);
        chk("drain_vld2", 32'(bus.byte_vld), 32'd0);
        step();
        chk("redir_req", 32'(bus.mem_req), 32'd1);
        chk("redir_addr", 32'(bus.mem_addr), 32'h10000);
        chk("redir_vld0", 32'(bus.byte_vld), 32'd0);
        mem_delay = 0;
        step();
        chk("redir_vld", 32'(bus.byte_vld), 32'd1);
        chk("redir_p", 32'(bus.p_o), 32'h10000);
        chk("redir_byte", 32'(bus.byte_o), 32'h00);

        // Second redirect while draining retargets fp and stays in DRAIN
        go_outstanding();
        bus.br_psel = 1'b1;
        bus.br_p = 17'h10000;
        step();
        bus.br_p = 17'h12340;
        step();
        bus.br_psel = 1'b0;
        chk("redrain_state", 32'(dut.state), 32'(DRAIN));
        chk("redrain_req", 32'(bus.mem_req), 32'd0);
        chk("redrain_addr", 32'(bus.mem_addr), 32'h12340);
        step();
        chk("redrain_req2", 32'(bus.mem_req), 32'd1);
        chk("redrain_addr2", 32'(bus.mem_addr), 32'h12340);
        mem_delay = 0;
        step();
        chk("redrain_p", 32'(bus.p_o), 32'h12340);
        chk("redrain_byte", 32'(bus.byte_o), 32'h40);

        // Redirect coincident with ack and pop: nothing pushed or popped
        do_reset();
        rst = 1'b1;
        mem_en = 1'b1;
        mem_delay = 0;
        bus.dec_rdy = 1'b1;
        repeat (4) step();
        chk("coin_pre_ack", 32'(bus.mem_ack), 32'd1);
        chk("coin_pre_vld", 32'(bus.byte_vld), 32'd1);
        bus.br_psel = 1'b1;
        bus.br_p = 17'h00abc;
        step();
        bus.br_psel = 1'b0;
        chk("coin_count", 32'(dut.u_fq.count), 32'd0);
        chk("coin_vld", 32'(bus.byte_vld), 32'd0);
        chk("coin_addr", 32'(bus.mem_addr), 32'h00abc);
        step();
        chk("coin_byte", 32'(bus.byte_o), 32'hbc);
        chk("coin_p", 32'(bus.p_o), 32'h00abc);

        // Fetch pointer wrap at the top of the address space
        bus.br_psel = 1'b1;
        bus.br_p = 17'h1fffe;
        step();
        bus.br_psel = 1'b0;
        chk("wrap_addr0", 32'(bus.mem_addr), 32'h1fffe);
        step();
        chk("wrap_addr1", 32'(bus.mem_addr), 32'h1ffff);
        chk("wrap_byte1", 32'(bus.byte_o), 32'hfe);
        step();
        chk("wrap_addr2", 32'(bus.mem_addr), 32'h00000);
        chk("wrap_p2", 32'(bus.p_o), 32'h1ffff);
        step();
        chk("wrap_p3", 32'(bus.p_o), 32'h00000);
        chk("wrap_byte3", 32'(bus.byte_o), 32'h00);

        // Reset mid-request, then a stale ack after release is ignored
        mem_en = 1'b0;
        do_reset();
        rst = 1'b1;
        bus.dec_rdy = 1'b1;
        step();
        chk("abn_req", 32'(bus.mem_req), 32'd1);
        rst = 1'b0;
        step();
        chk("abn_rst_req", 32'(bus.mem_req), 32'd0);
        chk("abn_rst_vld", 32'(bus.byte_vld), 32'd0);
        rst = 1'b1;
        ack_force = 1'b1;
        force_data = 8'h77;
        step();
        ack_force = 1'b0;
        chk("abn_count", 32'(dut.u_fq.count), 32'd0);
        chk("abn_vld", 32'(bus.byte_vld), 32'd0);
        chk("abn_addr", 32'(bus.mem_addr), 32'd0);
        step();
        chk("abn_vld2", 32'(bus.byte_vld), 32'd0);
        mem_en = 1'b1;
        step();
        chk("abn_fresh_vld", 32'(bus.byte_vld), 32'd1);
        chk("abn_fresh_byte", 32'(bus.byte_o), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
